matrix_input_parser: RTL

MATRIX_INPUT_PARSER -- requirements
Module: matrix_input_parser

---
 rtl/matrix_input_parser_if.sv | 31 +++
 rtl/matrix_input_parser.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/matrix_input_parser_if.sv
// Bundle of the parser's control, UART byte, range and element-write signals.
// The master drives the byte stream and range limits; the slave is the parser.
interface matrix_input_parser_if;
    logic       start;
    logic       abort;
    logic [7:0] rx_data;
    logic       rx_done;
    logic [7:0] val_min;
    logic [7:0] val_max;
    logic       busy;
    logic       wr_en;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic [2:0] mat_m;
    logic [2:0] mat_n;
    logic       parse_done;
    logic       parse_error;
    logic [2:0] err_code;

    modport master (
        output start, abort, rx_data, rx_done, val_min, val_max,
        input  busy, wr_en, wr_addr, wr_data, mat_m, mat_n,
               parse_done, parse_error, err_code
    );

    modport slave (
        input  start, abort, rx_data, rx_done, val_min, val_max,
        output busy, wr_en, wr_addr, wr_data, mat_m, mat_n,
               parse_done, parse_error, err_code
    );
endinterface

// File: rtl/matrix_input_parser.sv
// Parses an ASCII matrix "M N e0 e1 ..." from a UART byte stream and emits
// one row-major element write per accepted token.
module matrix_input_parser (
    input  logic                 clk_100m,
    input  logic                 rst_n,
    matrix_input_parser_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        GET_M,
        GET_N,
        GET_ELEM
    } state_t;

    typedef enum logic [2:0] {
        ERR_NONE     = 3'd0,
        ERR_CHAR     = 3'd1,
        ERR_DIM      = 3'd2,
        ERR_VALUE    = 3'd3,
        ERR_OVERFLOW = 3'd4
    } err_t;

    localparam logic [1:0] MAX_DIGITS = 2'd3;

    state_t     state_q, state_d;
    logic [9:0] acc_q, acc_d;
    logic [1:0] ndig_q, ndig_d;
    logic [4:0] cnt_q, cnt_d;
    logic       fin_q, fin_d;
    logic [2:0] mat_m_q, mat_m_d;
    logic [2:0] mat_n_q, mat_n_d;
    logic       wr_en_q, wr_en_d;
    logic [4:0] wr_addr_q, wr_addr_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic       done_q, done_d;
    logic       error_q, error_d;
    err_t       err_code_q, err_code_d;

    logic       is_digit;
    logic       is_sep;
    logic [3:0] digit;
    logic [9:0] acc_shift;
    logic [5:0] elem_total;
    logic [5:0] cnt_next;
    logic       dim_ok;
    logic       val_ok;
    logic       raise;
    err_t       raise_code;

    // ASCII '0'..'9' carry their value in the low nibble.
    assign is_digit   = (bus.rx_data >= 8'h30) && (bus.rx_data <= 8'h39);
    assign digit      = bus.rx_data[3:0];
    assign is_sep     = (bus.rx_data == 8'h20) || (bus.rx_data == 8'h0D) ||
                        (bus.rx_data == 8'h0A) || (bus.rx_data == 8'h2C);
    assign acc_shift  = (acc_q << 3) + (acc_q << 1) + {6'd0, digit};
    assign elem_total = {3'd0, mat_m_q} * {3'd0, mat_n_q};
    assign cnt_next   = {1'b0, cnt_q} + 6'd1;
    assign dim_ok     = (acc_q >= 10'd1) && (acc_q <= 10'd5);
    assign val_ok     = (acc_q[7:0] >= bus.val_min) && (acc_q[7:0] <= bus.val_max);

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        ndig_d     = ndig_q;
        cnt_d      = cnt_q;
        fin_d      = fin_q;
        mat_m_d    = mat_m_q;
        mat_n_d    = mat_n_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        done_d     = 1'b0;
        error_d    = 1'b0;
        err_code_d = err_code_q;
        raise      = 1'b0;
        raise_code = ERR_NONE;

        if (bus.abort) begin
            // Abort beats everything, including a byte arriving in the same cycle.
            state_d = IDLE;
            fin_d   = 1'b0;
        end else if (state_q == IDLE) begin
            if (bus.start) begin
                state_d    = GET_M;
                err_code_d = ERR_NONE;
                acc_d      = '0;
                ndig_d     = '0;
                cnt_d      = '0;
                fin_d      = 1'b0;
            end
        end else if (fin_q) begin
            // Last element was written this cycle; finish one cycle later.
            state_d = IDLE;
            fin_d   = 1'b0;
            done_d  = 1'b1;
        end else if (bus.rx_done) begin
            if (is_digit) begin
                if (ndig_q == MAX_DIGITS) begin
                    raise      = 1'b1;
                    raise_code = ERR_OVERFLOW;
                end else begin
                    acc_d  = acc_shift;
                    ndig_d = ndig_q + 2'd1;
                end
            end else if (is_sep) begin
                if (ndig_q != 2'd0) begin
                    acc_d  = '0;
                    ndig_d = '0;
                    if (acc_q > 10'd255) begin
                        raise      = 1'b1;
                        raise_code = ERR_OVERFLOW;
                    end else begin
                        case (state_q)
                            GET_M: begin
                                if (dim_ok) begin
                                    mat_m_d = acc_q[2:0];
                                    state_d = GET_N;
                                end else begin
                                    raise      = 1'b1;
                                    raise_code = ERR_DIM;
                                end
                            end
                            GET_N: begin
                                if (dim_ok) begin
                                    mat_n_d = acc_q[2:0];
                                    state_d = GET_ELEM;
                                end else begin
                                    raise      = 1'b1;
                                    raise_code = ERR_DIM;
                                end
                            end
                            GET_ELEM: begin
                                if (val_ok) begin
                                    wr_en_d   = 1'b1;
                                    wr_addr_d = cnt_q;
                                    wr_data_d = acc_q[7:0];
                                    cnt_d     = cnt_next[4:0];
                                    fin_d     = (cnt_next == elem_total);
                                end else begin
                                    raise      = 1'b1;
                                    raise_code = ERR_VALUE;
                                end
                            end
                            default: begin
                                state_d = IDLE;
                            end
                        endcase
                    end
                end
            end else begin
                raise      = 1'b1;
                raise_code = ERR_CHAR;
            end

            if (raise) begin
                state_d    = IDLE;
                error_d    = 1'b1;
                err_code_d = raise_code;
                acc_d      = '0;
                ndig_d     = '0;
                fin_d      = 1'b0;
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments and every register,
    // outputs included, is cleared by the asynchronous reset.
    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            ndig_q     <= '0;
            cnt_q      <= '0;
            fin_q      <= 1'b0;
            mat_m_q    <= '0;
            mat_n_q    <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            ndig_q     <= ndig_d;
            cnt_q      <= cnt_d;
            fin_q      <= fin_d;
            mat_m_q    <= mat_m_d;
            mat_n_q    <= mat_n_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            done_q     <= done_d;
            error_q    <= error_d;
            err_code_q <= err_code_d;
        end
    end

    assign bus.busy        = (state_q != IDLE);
    assign bus.wr_en       = wr_en_q;
    assign bus.wr_addr     = wr_addr_q;
    assign bus.wr_data     = wr_data_q;
    assign bus.mat_m       = mat_m_q;
    assign bus.mat_n       = mat_n_q;
    assign bus.parse_done  = done_q;
    assign bus.parse_error = error_q;
    assign bus.err_code    = err_code_q;

endmodule
